// File: rtl/sensor_ar_multi.sv
// sensor_ar_multi: independent per-channel debouncer with rise/fall pulses; SENSOR_AR_SYNC_EN adds a 2-flop input synchronizer.
// Output changes on the edge registering the T-th consecutive differing sample (+2 cycles when synchronized); no backpressure.
module sensor_ar_multi #(
  parameter int N_CH      = 4,
  parameter int COUNT_ON  = 10,
  parameter int COUNT_OFF = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sensor_in,
  output logic [N_CH-1:0] sensor_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse
);

  localparam int CMAX = (COUNT_ON > COUNT_OFF) ? COUNT_ON : COUNT_OFF;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] ON_LAST  = CW'(COUNT_ON - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(COUNT_OFF - 1);

  logic [N_CH-1:0] samp;

`ifdef SENSOR_AR_SYNC_EN
  logic [N_CH-1:0] sync_q1;
  logic [N_CH-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= sensor_in;
      sync_q2 <= sync_q1;
    end
  end

  assign samp = sync_q2;
`else
  assign samp = sensor_in;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] last;
    logic          out_q;
    logic          rise_q;
    logic          fall_q;

    // Threshold follows the direction the output would move in.
    assign last = samp[i] ? ON_LAST : OFF_LAST;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt    <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (samp[i] == out_q) begin
          cnt <= '0;
        end else if (cnt == last) begin
          cnt    <= '0;
          out_q  <= samp[i];
          rise_q <= samp[i];
          fall_q <= ~samp[i];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign sensor_out[i] = out_q;
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;
  end

endmodule
